// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store front end: sub-word RMW stores, lane-extracted loads, one response per request
module mem_access_unit #(
    parameter int ADDR_WIDTH      = 32,
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [31:0]           mem_wd,
    input  logic [31:0]           mem_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rd_q, rd_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    misaligned;
    logic                    reserved;
    logic                    reject;
    logic [31:0]             shift_b;
    logic [31:0]             shift_h;
    logic [31:0]             load_val;
    logic [31:0]             merged;

    always_comb begin
        misaligned = 1'b0;
        reserved   = 1'b0;
        case (req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = |req_addr[1:0];
            default: reserved   = 1'b1;
        endcase
        // Reserved size is always an error; only true misalignment may be forced aligned.
        reject = reserved | (misaligned & ERR_ON_MISALIGN);
    end

    always_comb begin
        shift_b  = mem_rd >> {addr_q[1:0], 3'b000};
        shift_h  = mem_rd >> {addr_q[1], 4'b0000};
        load_val = mem_rd;
        case (size_q)
            SZ_BYTE: load_val = uns_q ? {24'd0, shift_b[7:0]}  : {{24{shift_b[7]}}, shift_b[7:0]};
            SZ_HALF: load_val = uns_q ? {16'd0, shift_h[15:0]} : {{16{shift_h[15]}}, shift_h[15:0]};
            default: load_val = mem_rd;
        endcase
    end

    always_comb begin
        merged = rd_q;
        case (size_q)
            SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    rdata_d = 32'd0;
                    err_d   = reject;
                    addr_d  = req_addr;
                    if (!ERR_ON_MISALIGN) begin
                        if (req_size == SZ_HALF) addr_d[0]   = 1'b0;
                        if (req_size == SZ_WORD) addr_d[1:0] = 2'b00;
                    end
                    if (reject)
                        state_d = RESP;
                    else if (req_we && req_size == SZ_WORD)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                rd_d = mem_rd;
                if (we_q) begin
                    state_d = WRITE;
                end else begin
                    rdata_d = load_val;
                    state_d = RESP;
                end
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rd_q    <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory-side outputs decode from state so an async reset silences them immediately.
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
    assign rsp_err   = (state_q == RESP) ? err_q : 1'b0;
    assign mem_we    = (state_q == WRITE);
    assign mem_wd    = (state_q == WRITE) ? merged : 32'd0;
    assign mem_a     = (state_q == READ || state_q == WRITE) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;

endmodule
